// File: rtl/ulpi_phy_responder_pkg.sv
// Shared ULPI command codes, PHY register addresses, FSM states and triple-register decode helpers.
// No logic of its own; imported by the responder top and its register file.
package ulpi_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_TX   = 2'b01,
        CMD_REGW = 2'b10,
        CMD_REGR = 2'b11
    } ulpi_cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_ACK,
        ST_W_DATA,
        ST_W_STP,
        ST_R_ACK,
        ST_R_TURN,
        ST_R_DATA,
        ST_R_BACK,
        ST_X_TURN,
        ST_X_DATA,
        ST_X_BACK
    } ulpi_state_e;

    localparam logic [5:0] ID_LAST         = 6'h03;
    localparam logic [5:0] FUNC_CTRL       = 6'h04;
    localparam logic [5:0] IFC_CTRL        = 6'h07;
    localparam logic [5:0] OTG_CTRL        = 6'h0A;
    localparam logic [5:0] USB_INT_EN_RISE = 6'h0D;
    localparam logic [5:0] USB_INT_EN_FALL = 6'h10;
    localparam logic [5:0] USB_INT_STATUS  = 6'h13;
    localparam logic [5:0] SCRATCH         = 6'h16;
    localparam logic [5:0] VENDOR_BASE     = 6'h30;

    localparam int         N_TRIPLES       = 6;
    localparam logic [7:0] FUNC_CTRL_RST   = 8'h41;

    function automatic logic is_triple(input logic [5:0] a);
        return ((a >= FUNC_CTRL) && (a < USB_INT_STATUS)) ||
               ((a >= SCRATCH) && (a <= SCRATCH + 6'd2));
    endfunction

    // Only meaningful when is_triple(a) holds.
    function automatic logic [2:0] triple_idx(input logic [5:0] a);
        if (a >= SCRATCH)              return 3'd5;
        else if (a >= USB_INT_EN_FALL) return 3'd4;
        else if (a >= USB_INT_EN_RISE) return 3'd3;
        else if (a >= OTG_CTRL)        return 3'd2;
        else if (a >= IFC_CTRL)        return 3'd1;
        else                           return 3'd0;
    endfunction

    function automatic logic [5:0] triple_base(input logic [2:0] idx);
        case (idx)
            3'd1:    return IFC_CTRL;
            3'd2:    return OTG_CTRL;
            3'd3:    return USB_INT_EN_RISE;
            3'd4:    return USB_INT_EN_FALL;
            3'd5:    return SCRATCH;
            default: return FUNC_CTRL;
        endcase
    endfunction

endpackage

// File: rtl/ulpi_phy_responder_regfile.sv
// ULPI PHY register map: read-only IDs, set/clear triples, status, vendor scratch space.
// Combinational read; writes commit on i_wr_en and the report strobe follows one cycle later.
module ulpi_phy_regfile #(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr_en,
    input  logic [5:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic [5:0] i_rd_addr,
    input  logic [7:0] i_status,
    output logic [7:0] o_rd_data,
    output logic       o_wr_pulse,
    output logic [5:0] o_wr_addr,
    output logic [7:0] o_wr_data
);
    import ulpi_pkg::*;

    logic [7:0] r_trip [0:N_TRIPLES-1];
    logic [7:0] r_vend [0:15];
    logic       r_wr_pulse;
    logic [5:0] r_wr_addr;
    logic [7:0] r_wr_data;

    logic [2:0] w_idx;
    logic [1:0] w_off;
    logic [7:0] w_cur;
    logic [7:0] w_new;
    logic [7:0] w_rd_data;
    logic       w_trip_wr;
    logic       w_vend_wr;

    assign w_idx     = triple_idx(i_wr_addr);
    assign w_off     = 2'(i_wr_addr - triple_base(w_idx));
    assign w_cur     = r_trip[w_idx];
    assign w_trip_wr = i_wr_en && is_triple(i_wr_addr);
    assign w_vend_wr = i_wr_en && (i_wr_addr >= VENDOR_BASE);

    // Offset within a triple selects plain write, bit-set or bit-clear.
    always_comb begin
        w_new = i_wr_data;
        case (w_off)
            2'd1:    w_new = w_cur | i_wr_data;
            2'd2:    w_new = w_cur & ~i_wr_data;
            default: w_new = i_wr_data;
        endcase
    end

    always_comb begin
        w_rd_data = 8'h00;
        if (i_rd_addr <= ID_LAST) begin
            case (i_rd_addr[1:0])
                2'd0:    w_rd_data = VENDOR_ID[7:0];
                2'd1:    w_rd_data = VENDOR_ID[15:8];
                2'd2:    w_rd_data = PRODUCT_ID[7:0];
                default: w_rd_data = PRODUCT_ID[15:8];
            endcase
        end else if (is_triple(i_rd_addr)) begin
            w_rd_data = r_trip[triple_idx(i_rd_addr)];
        end else if (i_rd_addr == USB_INT_STATUS) begin
            w_rd_data = i_status;
        end else if (i_rd_addr >= VENDOR_BASE) begin
            w_rd_data = r_vend[i_rd_addr[3:0]];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < N_TRIPLES; i++) begin
                r_trip[i] <= (i == 0) ? FUNC_CTRL_RST : 8'h00;
            end
            for (int i = 0; i < 16; i++) begin
                r_vend[i] <= 8'h00;
            end
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= 6'h00;
            r_wr_data  <= 8'h00;
        end else begin
            r_wr_pulse <= w_trip_wr || w_vend_wr;
            if (w_trip_wr) begin
                r_trip[w_idx] <= w_new;
                r_wr_addr     <= triple_base(w_idx);
                r_wr_data     <= w_new;
            end else if (w_vend_wr) begin
                r_vend[i_wr_addr[3:0]] <= i_wr_data;
                r_wr_addr              <= i_wr_addr;
                r_wr_data              <= i_wr_data;
            end
        end
    end

    assign o_rd_data  = w_rd_data;
    assign o_wr_pulse = r_wr_pulse;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;

endmodule

// File: rtl/ulpi_phy_responder.sv
// PHY-side ULPI endpoint answering link register reads/writes and injecting RX CMD bytes.
// Registered bus outputs; RX CMD requests wait (ready low) until the FSM is idle with a quiet bus.
module ulpi_phy_responder #(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_data_in,
    output logic [7:0] o_data_out,
    output logic       o_data_oe,
    output logic       o_dir,
    output logic       o_nxt,
    input  logic       i_stp,
    input  logic       i_rxcmd_valid,
    input  logic [7:0] i_rxcmd_data,
    output logic       o_rxcmd_ready,
    input  logic [7:0] i_status,
    output logic       o_reg_wr_pulse,
    output logic [5:0] o_reg_wr_addr,
    output logic [7:0] o_reg_wr_data,
    output logic       o_err
);
    import ulpi_pkg::*;

    ulpi_state_e r_state;
    ulpi_state_e w_next;

    logic [5:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rxbyte;
    logic [7:0] r_dout;
    logic       r_dir;
    logic       r_nxt;
    logic       r_oe;
    logic       r_err;

    logic       w_err;
    logic       w_wr_en;
    logic       w_rx_hs;
    logic       w_ready;
    logic [7:0] w_rd_data;

    // A nonzero link byte always wins over a pending RX CMD.
    assign w_ready = (r_state == ST_IDLE) && (i_data_in == 8'h00);

    always_comb begin
        w_next  = r_state;
        w_err   = 1'b0;
        w_wr_en = 1'b0;
        w_rx_hs = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_data_in != 8'h00) begin
                    case (ulpi_cmd_e'(i_data_in[7:6]))
                        CMD_REGW: w_next = ST_W_ACK;
                        CMD_REGR: w_next = ST_R_ACK;
                        default:  w_err  = 1'b1;
                    endcase
                end else if (i_rxcmd_valid) begin
                    w_rx_hs = 1'b1;
                    w_next  = ST_X_TURN;
                end
            end
            ST_W_ACK:  w_next = i_stp ? ST_IDLE : ST_W_DATA;
            ST_W_DATA: w_next = i_stp ? ST_IDLE : ST_W_STP;
            ST_W_STP: begin
                w_wr_en = i_stp;
                w_err   = !i_stp;
                w_next  = ST_IDLE;
            end
            ST_R_ACK:  w_next = ST_R_TURN;
            ST_R_TURN: w_next = ST_R_DATA;
            ST_R_DATA: w_next = ST_R_BACK;
            ST_R_BACK: w_next = ST_IDLE;
            ST_X_TURN: w_next = ST_X_DATA;
            ST_X_DATA: w_next = ST_X_BACK;
            ST_X_BACK: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= 6'h00;
            r_wdata  <= 8'h00;
            r_rxbyte <= 8'h00;
            r_dout   <= 8'h00;
            r_dir    <= 1'b0;
            r_nxt    <= 1'b0;
            r_oe     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err;
            if ((r_state == ST_IDLE) && (i_data_in != 8'h00)) begin
                r_addr <= i_data_in[5:0];
            end
            if (r_state == ST_W_DATA) begin
                r_wdata <= i_data_in;
            end
            if (w_rx_hs) begin
                r_rxbyte <= i_rxcmd_data;
            end
            r_nxt <= (w_next == ST_W_ACK) || (w_next == ST_W_DATA) || (w_next == ST_R_ACK);
            r_dir <= (w_next == ST_R_TURN) || (w_next == ST_R_DATA) ||
                     (w_next == ST_X_TURN) || (w_next == ST_X_DATA);
            r_oe  <= (w_next == ST_R_DATA) || (w_next == ST_X_DATA);
            case (w_next)
                ST_R_DATA: r_dout <= w_rd_data;
                ST_X_DATA: r_dout <= r_rxbyte;
                default:   r_dout <= 8'h00;
            endcase
        end
    end

    ulpi_phy_regfile #(
        .VENDOR_ID  (VENDOR_ID),
        .PRODUCT_ID (PRODUCT_ID)
    ) u_regfile (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (r_addr),
        .i_wr_data  (r_wdata),
        .i_rd_addr  (r_addr),
        .i_status   (i_status),
        .o_rd_data  (w_rd_data),
        .o_wr_pulse (o_reg_wr_pulse),
        .o_wr_addr  (o_reg_wr_addr),
        .o_wr_data  (o_reg_wr_data)
    );

    assign o_data_out    = r_dout;
    assign o_data_oe     = r_oe;
    assign o_dir         = r_dir;
    assign o_nxt         = r_nxt;
    assign o_err         = r_err;
    assign o_rxcmd_ready = w_ready;

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// Randomized register/RX CMD traffic against a behavioural ULPI PHY register model.
module tb_ulpi_phy_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in, data_out, rxd, status, wr_data;
    logic       oe, dir, nxt, stp, rxv, rxr, wr_pulse, err;
    logic [5:0] wr_addr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:63];

    always #5 clk = ~clk;

    ulpi_phy_responder dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_data_in      (data_in),
        .o_data_out     (data_out),
        .o_data_oe      (oe),
        .o_dir          (dir),
        .o_nxt          (nxt),
        .i_stp          (stp),
        .i_rxcmd_valid  (rxv),
        .i_rxcmd_data   (rxd),
        .o_rxcmd_ready  (rxr),
        .i_status       (status),
        .o_reg_wr_pulse (wr_pulse),
        .o_reg_wr_addr  (wr_addr),
        .o_reg_wr_data  (wr_data),
        .o_err          (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_trip(input int a);
        return (a >= 4 && a <= 18) || (a >= 22 && a <= 24);
    endfunction

    function automatic int tbase(input int a);
        return (a <= 18) ? 4 + ((a - 4) / 3) * 3 : 22;
    endfunction

    function automatic logic [7:0] m_read(input int a);
        if (a == 0)        return 8'h24;
        else if (a == 1)   return 8'h04;
        else if (a == 2)   return 8'h09;
        else if (a == 3)   return 8'h00;
        else if (is_trip(a)) return mem[tbase(a)];
        else if (a == 19)  return status;
        else if (a >= 48)  return mem[a];
        else               return 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[4] = 8'h41;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] d, input logic stp_ok);
        logic       exp_p;
        logic [5:0] exp_a;
        logic [7:0] exp_d;
        int         b;
        exp_p = 1'b0; exp_a = 6'h00; exp_d = 8'h00;
        if (stp_ok) begin
            if (is_trip(a)) begin
                b = tbase(a);
                if (a == b)          mem[b] = d;
                else if (a == b + 1) mem[b] = mem[b] | d;
                else                 mem[b] = mem[b] & ~d;
                exp_p = 1'b1; exp_a = 6'(b); exp_d = mem[b];
            end else if (a >= 48) begin
                mem[a] = d;
                exp_p = 1'b1; exp_a = a; exp_d = d;
            end
        end
        data_in = {2'b10, a}; stp = 1'b0; #1;
        n_cmp++; if (rxr !== 1'b0) begin n_bad++; $display("FAIL w_ready_t0 got %b want 0", rxr); end
        tick();
        n_cmp++; if ({dir, nxt, oe} !== 3'b010) begin n_bad++; $display("FAIL w_t1 dir/nxt/oe got %b want 010", {dir, nxt, oe}); end
        tick(); data_in = d;
        n_cmp++; if ({dir, nxt, oe} !== 3'b010) begin n_bad++; $display("FAIL w_t2 dir/nxt/oe got %b want 010", {dir, nxt, oe}); end
        tick(); data_in = 8'h00; stp = stp_ok;
        n_cmp++; if ({dir, nxt, oe, err} !== 4'b0000) begin n_bad++; $display("FAIL w_t3 dir/nxt/oe/err got %b want 0000", {dir, nxt, oe, err}); end
        tick(); stp = 1'b0;
        n_cmp++; if ({wr_pulse, err} !== {exp_p, ~stp_ok}) begin n_bad++; $display("FAIL w_t4 addr %h pulse/err got %b want %b", a, {wr_pulse, err}, {exp_p, ~stp_ok}); end
        if (exp_p) begin
            n_cmp++; if ({wr_addr, wr_data} !== {exp_a, exp_d}) begin n_bad++; $display("FAIL w_report addr/data got %h/%h want %h/%h", wr_addr, wr_data, exp_a, exp_d); end
        end
    endtask

    task automatic do_read(input logic [5:0] a);
        logic [7:0] exp;
        status = 8'($urandom);
        exp = m_read(a);
        data_in = {2'b11, a}; #1;
        n_cmp++; if (rxr !== 1'b0) begin n_bad++; $display("FAIL r_ready_t0 got %b want 0", rxr); end
        tick(); data_in = 8'h00;
        n_cmp++; if ({dir, nxt, oe} !== 3'b010) begin n_bad++; $display("FAIL r_t1 dir/nxt/oe got %b want 010", {dir, nxt, oe}); end
        tick();
        n_cmp++; if ({dir, nxt, oe} !== 3'b100) begin n_bad++; $display("FAIL r_t2 dir/nxt/oe got %b want 100", {dir, nxt, oe}); end
        tick();
        n_cmp++; if ({dir, nxt, oe, data_out} !== {3'b101, exp}) begin n_bad++; $display("FAIL r_t3 addr %h dir/nxt/oe/data got %b/%h want 101/%h", a, {dir, nxt, oe}, data_out, exp); end
        tick();
        n_cmp++; if ({dir, nxt, oe} !== 3'b000) begin n_bad++; $display("FAIL r_t4 dir/nxt/oe got %b want 000", {dir, nxt, oe}); end
        tick();
    endtask

    task automatic do_rx(input logic [7:0] b);
        rxv = 1'b1; rxd = b; data_in = 8'h00; #1;
        n_cmp++; if (rxr !== 1'b1) begin n_bad++; $display("FAIL x_ready_t0 got %b want 1", rxr); end
        tick(); rxv = 1'b0;
        n_cmp++; if ({dir, nxt, oe} !== 3'b100) begin n_bad++; $display("FAIL x_t1 dir/nxt/oe got %b want 100", {dir, nxt, oe}); end
        tick();
        n_cmp++; if ({dir, oe, data_out} !== {2'b11, b}) begin n_bad++; $display("FAIL x_t2 dir/oe/data got %b/%h want 11/%h", {dir, oe}, data_out, b); end
        tick();
        n_cmp++; if ({dir, nxt, oe} !== 3'b000) begin n_bad++; $display("FAIL x_t3 dir/nxt/oe got %b want 000", {dir, nxt, oe}); end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; data_in = 8'h00; stp = 1'b0; rxv = 1'b0; rxd = 8'h00; status = 8'h00;
        model_reset();
        tick(); tick();
        n_cmp++; if ({dir, nxt, oe, data_out, wr_pulse, err} !== 13'h0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", {dir, nxt, oe, data_out, wr_pulse, err}); end
        rst = 1'b0;
        tick();
        do_read(6'h04);
        do_read(6'h07);
    endtask

    task automatic test_regw_basic();
        do_write(6'h04, 8'h55, 1'b1);
        do_read(6'h04);
    endtask

    task automatic test_set_clear();
        do_write(6'h16, 8'hF0, 1'b1);
        do_write(6'h17, 8'h0F, 1'b1);
        do_write(6'h18, 8'h3C, 1'b1);
        do_read(6'h16); do_read(6'h17); do_read(6'h18);
    endtask

    task automatic test_ids_status();
        for (int i = 0; i < 4; i++) do_read(6'(i));
        do_read(6'h13); do_read(6'h14); do_read(6'h15);
        do_write(6'h01, 8'hFF, 1'b1);
        do_write(6'h13, 8'hFF, 1'b1);
        do_read(6'h01);
    endtask

    task automatic test_rxcmd();
        do_rx(8'h4A);
        rxv = 1'b1; rxd = 8'h4A;
        do_write(6'h01, 8'($urandom), 1'b1);
        do_rx(8'h4A);
        rxv = 1'b1; rxd = 8'hC7;
        do_write(6'h31, 8'h5A, 1'b1);
        do_rx(8'hC7);
    endtask

    task automatic test_errors();
        do_write(6'h07, 8'hA5, 1'b0);
        do_read(6'h07);
        for (int i = 0; i < 6; i++) begin
            data_in = (i == 0) ? 8'h40 : 8'($urandom_range(1, 127));
            tick(); data_in = 8'h00;
            n_cmp++; if ({nxt, dir, err} !== 3'b001) begin n_bad++; $display("FAIL bad_cmd_t1 nxt/dir/err got %b want 001", {nxt, dir, err}); end
            tick();
            n_cmp++; if ({nxt, dir, err} !== 3'b000) begin n_bad++; $display("FAIL bad_cmd_t2 nxt/dir/err got %b want 000", {nxt, dir, err}); end
        end
    endtask

    task automatic test_abort();
        data_in = 8'hB0;
        tick(); stp = 1'b1;
        n_cmp++; if (nxt !== 1'b1) begin n_bad++; $display("FAIL abort1_t1 nxt got %b want 1", nxt); end
        tick(); stp = 1'b0; data_in = 8'h00;
        n_cmp++; if ({nxt, err} !== 2'b00) begin n_bad++; $display("FAIL abort1_t2 nxt/err got %b want 00", {nxt, err}); end
        tick();
        n_cmp++; if ({wr_pulse, err} !== 2'b00) begin n_bad++; $display("FAIL abort1_t3 pulse/err got %b want 00", {wr_pulse, err}); end
        data_in = 8'hB0;
        tick();
        tick(); stp = 1'b1; data_in = 8'hEE;
        n_cmp++; if (nxt !== 1'b1) begin n_bad++; $display("FAIL abort2_t2 nxt got %b want 1", nxt); end
        tick(); stp = 1'b0; data_in = 8'h00;
        n_cmp++; if (nxt !== 1'b0) begin n_bad++; $display("FAIL abort2_t3 nxt got %b want 0", nxt); end
        tick();
        n_cmp++; if ({wr_pulse, err} !== 2'b00) begin n_bad++; $display("FAIL abort2_t4 pulse/err got %b want 00", {wr_pulse, err}); end
        do_read(6'h30);
    endtask

    task automatic test_random();
        int op;
        logic [5:0] a;
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            a = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(4, 24));
            if (op < 4)      do_write(a, 8'($urandom), $urandom_range(0, 7) != 0);
            else if (op < 8) do_read(a);
            else             do_rx(8'($urandom));
        end
    endtask

    task automatic test_reset_mid_read();
        do_write(6'h04, 8'h99, 1'b1);
        data_in = 8'hC4;
        tick(); data_in = 8'h00;
        tick();
        tick();
        n_cmp++; if ({dir, oe} !== 2'b11) begin n_bad++; $display("FAIL rst_mid_pre dir/oe got %b want 11", {dir, oe}); end
        rst = 1'b1; #1;
        n_cmp++; if ({dir, nxt, oe, data_out} !== 11'h0) begin n_bad++; $display("FAIL rst_mid_async got %h want 0", {dir, nxt, oe, data_out}); end
        tick(); rst = 1'b0;
        model_reset();
        tick();
        do_read(6'h04);
    endtask

    initial begin
        test_reset();
        test_regw_basic();
        test_set_clear();
        test_ids_status();
        test_rxcmd();
        test_errors();
        test_abort();
        test_random();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ulpi_phy_responder.md
# ulpi_phy_responder

Synthesizable PHY-side ULPI endpoint. It answers link-issued TX CMD register writes and reads against an internal ULPI register file, and injects RX CMD bytes supplied by a status source. It sits opposite `ulpi_link` in loopback benches and FPGA bring-up, replacing an external transceiver for register-path testing. USB packet transmit and receive data are out of scope.

## Interface
- `VENDOR_ID`, default 16'h0424: read-only regs 0x00 (low byte) and 0x01 (high byte).
- `PRODUCT_ID`, default 16'h0009: read-only regs 0x02 (low byte) and 0x03 (high byte).
- `clk` in 1: ULPI 60 MHz clock, all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `data_in` in 8: ULPI data as driven by the link.
- `data_out` out 8: PHY-driven ULPI data.
- `data_oe` out 1: PHY drives the bus when 1.
- `dir` out 1: ULPI dir.
- `nxt` out 1: ULPI nxt.
- `stp` in 1: ULPI stp from the link.
- `rxcmd_valid` in 1: RX CMD request from the status source.
- `rxcmd_data` in 8: RX CMD byte.
- `rxcmd_ready` out 1: handshake completes when `rxcmd_valid & rxcmd_ready`.
- `status` in 8: value returned by reg 0x13.
- `reg_wr_pulse` out 1: one-cycle strobe when a register write commits.
- `reg_wr_addr` out 6: committed address (base address for set/clear).
- `reg_wr_data` out 8: resulting register value.
- `err` out 1: one-cycle pulse on an unsupported command or a protocol violation.

## Operation
- FSM states: IDLE, W_ACK, W_DATA, W_STP, R_ACK, R_TURN, R_DATA, R_BACK, X_TURN, X_DATA, X_BACK.
- In IDLE, when `data_in != 0`:
  - `data_in[7:6]`=10 (REGW): latch addr[5:0], go to W_ACK.
  - `data_in[7:6]`=11 (REGR): latch addr[5:0], go to R_ACK.
  - Any other value: `err` pulse, stay in IDLE, no `nxt`.
- RX CMD:
  - `rxcmd_ready` = (state==IDLE) & (`data_in`==0), combinational.
  - On handshake, capture the byte and go to X_TURN.
  - A link command in the same cycle wins: `rxcmd_ready` is 0 whenever `data_in != 0`.
- Register map, in sub-module:
  - 0x00–0x03: read-only IDs; writes are dropped with no pulse.
  - 0x04–0x12 and 0x16–0x18: triples (base, base+1 set, base+2 clear).
    - Write to base: value = data.
    - Write to set: value = value | data.
    - Write to clear: value = value & ~data.
    - A read at any offset of a triple returns the stored value.
  - 0x13: reads `status`. 0x14, 0x15: read 0.
  - 0x30–0x3F: plain read/write.
  - All other addresses read 0 and drop writes (no pulse, no err).
  - Reset values: all storage 0, except 0x04 = 8'h41 and 0x07 = 8'h00.
- `reg_wr_addr` reports the triple base address.

## Timing
- Reset values: `dir`=0, `nxt`=0, `data_oe`=0, `data_out`=0, `reg_wr_pulse`=0, `err`=0, FSM in IDLE.
- Reset mid-transaction: the bus is released immediately and an in-flight write is discarded.
- All bus outputs are registered. T0 is the cycle in which the command is sampled.
- REGW:
  - T1: `nxt`=1 (command accepted).
  - T2: `nxt`=1; data is sampled at the end of T2.
  - T3: `nxt`=0; `stp` must be 1. The write commits at the end of T3.
  - `reg_wr_pulse` is high in T4.
  - If `stp`=0 in T3: discard the write, `err` pulse, return to IDLE.
  - If `stp`=1 in T1 or T2: abort with no write, return to IDLE.
- REGR:
  - T1: `nxt`=1.
  - T2: `dir`=1, `nxt`=0, `data_oe`=0 (turnaround).
  - T3: `data_oe`=1, `data_out`=value.
  - T4: `dir`=0, `data_oe`=0.
  - T5: IDLE; a new command can be sampled.
- RX CMD, with handshake in T0:
  - T1: `dir`=1, `data_oe`=0.
  - T2: `data_oe`=1, `data_out`=byte.
  - T3: `dir`=0, `data_oe`=0.
  - T4: IDLE.
- `stp` and `data_in` are ignored while `dir`=1.
- Back-to-back RX CMDs are separated by at least one IDLE cycle.

## Structure
- `ulpi_pkg` holds:
  - `ulpi_cmd_e` (IDLE/TX/REGW/REGR on bits [7:6]);
  - register address localparams (FUNC_CTRL, IFC_CTRL, OTG_CTRL, USB_INT_EN_RISE/FALL, USB_INT_STATUS, SCRATCH, VENDOR_BASE);
  - the turnaround state enum.
- Sub-module `ulpi_phy_regfile` holds the map decode, set/clear arithmetic and read mux. The FSM stays in the top.

## Test plan
- REGW 0x84, data 0x55, `stp` in T3 -> `nxt` high in T1–T2; `reg_wr_pulse` with addr 0x04 and data 0x55; a later read of 0x04 returns 0x55.
- Set/clear: write 0x16 = 0xF0, then 0x17 (set) = 0x0F, then 0x18 (clear) = 0x3C -> reads of 0x16/0x17/0x18 all return 0xC3.
- REGR 0xC0 and 0xC1 -> `data_out` 0x24 then 0x04, each at T3 with `dir` high T2–T3 and `data_oe` only in T3.
- `rxcmd_valid` with 0x4A while `data_in`=0 -> `rxcmd_ready` in T0; `data_out`=0x4A with `data_oe` in T2. The same request while the link drives 0x81 -> the write completes first, then the RX CMD goes out.
- Write with `stp` missing in T3 -> `err` pulse and register unchanged. Command 0x40 -> `err` pulse and no `nxt`.
- `reset` asserted during R_DATA -> `dir`/`data_oe` drop asynchronously and registers return to defaults (0x04 reads 0x41).
